// File: rtl/apb_modport_pkg.sv
// Shared definitions for the APB master/slave pair: default widths and the
// master state encoding.
package apb_modport_pkg;

  localparam int AW_DEF = 9;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_slave.sv
// Zero-wait-state APB slave: a register-file memory cleared by reset, written
// on a completed write and read combinationally through prdata.
module apb_slave
  import apb_modport_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          pclk,
  input  logic          presetn,
  input  logic          psel,
  input  logic          penable,
  input  logic          pwrite,
  input  logic [AW-2:0] paddr,
  input  logic [DW-1:0] pwdata,
  output logic          pready,
  output logic [DW-1:0] prdata
);

  localparam int DEPTH = 1 << (AW - 1);

  logic [DW-1:0] mem_r [DEPTH];

  assign pready = psel & penable;
  assign prdata = mem_r[paddr];

  // Memory array: cleared on reset, updated only when a write completes here
  always_ff @(posedge pclk or posedge presetn) begin
    if (presetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (pready && pwrite) begin
      mem_r[paddr] <= pwdata;
    end
  end

endmodule

// File: rtl/apb_modport.sv
// APB master FSM (IDLE/SETUP/ACCESS) driving two apb_slave instances; the top
// address bit selects the slave and completed reads land in apb_read_data_out.
module apb_modport
  import apb_modport_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          pclk,
  input  logic          presetn,
  input  logic          transfer,
  input  logic          READ_WRITE,
  input  logic [AW-1:0] apb_write_paddr,
  input  logic [AW-1:0] apb_read_paddr,
  input  logic [DW-1:0] apb_write_data,
  output logic [DW-1:0] apb_read_data_out
);

  apb_state_e    state_r;
  apb_state_e    next_state_s;
  logic          capture_s;
  logic          pwrite_r;
  logic [AW-1:0] paddr_r;
  logic [DW-1:0] pwdata_r;
  logic [DW-1:0] read_data_r;
  logic          psel1_s;
  logic          psel2_s;
  logic          penable_s;
  logic          pready1_s;
  logic          pready2_s;
  logic          pready_s;
  logic [DW-1:0] prdata1_s;
  logic [DW-1:0] prdata2_s;
  logic [DW-1:0] prdata_s;

  // Next-state logic; capture_s marks every edge that launches a new transfer
  always_comb begin
    next_state_s = state_r;
    capture_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (transfer) begin
          next_state_s = SETUP;
          capture_s    = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      SETUP: next_state_s = ACCESS;
      ACCESS: begin
        if (pready_s && transfer) begin
          next_state_s = SETUP;
          capture_s    = 1'b1;
        end else if (pready_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = ACCESS;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Bus control decode from the state and the captured address
  always_comb begin
    psel1_s   = 1'b0;
    psel2_s   = 1'b0;
    penable_s = (state_r == ACCESS);
    if (state_r != IDLE) begin
      psel1_s = ~paddr_r[AW-1];
      psel2_s = paddr_r[AW-1];
    end else begin
      psel1_s = 1'b0;
      psel2_s = 1'b0;
    end
  end

  assign pready_s = pready1_s | pready2_s;
  assign prdata_s = paddr_r[AW-1] ? prdata2_s : prdata1_s;

  // State register
  always_ff @(posedge pclk or posedge presetn) begin
    if (presetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Transfer capture: inputs are frozen here so later input changes cannot
  // disturb the transfer in flight
  always_ff @(posedge pclk or posedge presetn) begin
    if (presetn) begin
      pwrite_r <= 1'b0;
      paddr_r  <= '0;
      pwdata_r <= '0;
    end else if (capture_s) begin
      pwrite_r <= ~READ_WRITE;
      paddr_r  <= READ_WRITE ? apb_read_paddr : apb_write_paddr;
      pwdata_r <= apb_write_data;
    end
  end

  // Read data register: updated only on the edge a read completes
  always_ff @(posedge pclk or posedge presetn) begin
    if (presetn) begin
      read_data_r <= '0;
    end else if ((state_r == ACCESS) && pready_s && !pwrite_r) begin
      read_data_r <= prdata_s;
    end
  end

  assign apb_read_data_out = read_data_r;

  apb_slave #(.AW(AW), .DW(DW)) u_slave1 (
    .pclk    (pclk),
    .presetn (presetn),
    .psel    (psel1_s),
    .penable (penable_s),
    .pwrite  (pwrite_r),
    .paddr   (paddr_r[AW-2:0]),
    .pwdata  (pwdata_r),
    .pready  (pready1_s),
    .prdata  (prdata1_s)
  );

  apb_slave #(.AW(AW), .DW(DW)) u_slave2 (
    .pclk    (pclk),
    .presetn (presetn),
    .psel    (psel2_s),
    .penable (penable_s),
    .pwrite  (pwrite_r),
    .paddr   (paddr_r[AW-2:0]),
    .pwdata  (pwdata_r),
    .pready  (pready2_s),
    .prdata  (prdata2_s)
  );

endmodule

// File: tb/tb_apb_modport.sv
// Directed plus randomized bench for apb_modport against a flat 512-byte
// address-space model with a last-read register.
module tb_apb_modport;
  import apb_modport_pkg::*;

  logic       pclk;
  logic       presetn;
  logic       transfer;
  logic       READ_WRITE;
  logic [8:0] apb_write_paddr;
  logic [8:0] apb_read_paddr;
  logic [7:0] apb_write_data;
  logic [7:0] apb_read_data_out;

  int n_assert;
  int n_fail;

  logic [7:0] mem_m [512];
  logic [7:0] rdo_m;

  logic       sq_rd [4];
  logic [8:0] sq_a  [4];
  logic [7:0] sq_d  [4];

  apb_modport dut (
    .pclk              (pclk),
    .presetn           (presetn),
    .transfer          (transfer),
    .READ_WRITE        (READ_WRITE),
    .apb_write_paddr   (apb_write_paddr),
    .apb_read_paddr    (apb_read_paddr),
    .apb_write_data    (apb_write_data),
    .apb_read_data_out (apb_read_data_out)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 512; i++) mem_m[i] = 8'h00;
    rdo_m = 8'h00;
  endtask

  // Present one request; the unused address/data carry random noise
  task automatic set_in(input logic rd, input logic [8:0] a, input logic [7:0] d);
    READ_WRITE = rd;
    if (rd) begin
      apb_read_paddr  = a;
      apb_write_paddr = 9'($urandom);
      apb_write_data  = 8'($urandom);
    end else begin
      apb_write_paddr = a;
      apb_read_paddr  = 9'($urandom);
      apb_write_data  = d;
    end
  endtask

  task automatic scramble();
    READ_WRITE      = 1'($urandom);
    apb_write_paddr = 9'($urandom);
    apb_read_paddr  = 9'($urandom);
    apb_write_data  = 8'($urandom);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_state"}, 32'(dut.state_r), 32'(IDLE));
    chk({tag, "_psel1"}, {31'd0, dut.psel1_s}, 32'd0);
    chk({tag, "_psel2"}, {31'd0, dut.psel2_s}, 32'd0);
    chk({tag, "_penable"}, {31'd0, dut.penable_s}, 32'd0);
    chk({tag, "_rdo"}, {24'd0, apb_read_data_out}, {24'd0, rdo_m});
  endtask

  // Run sq_*[0..n-1] back to back with transfer held high; entered and left
  // at #1 after a rising edge with the master idle
  task automatic run_seq(input int n);
    set_in(sq_rd[0], sq_a[0], sq_d[0]);
    transfer = 1'b1;
    @(posedge pclk); #1;
    for (int k = 0; k < n; k++) begin
      chk("setup_state", 32'(dut.state_r), 32'(SETUP));
      chk("setup_psel1", {31'd0, dut.psel1_s}, {31'd0, ~sq_a[k][8]});
      chk("setup_psel2", {31'd0, dut.psel2_s}, {31'd0, sq_a[k][8]});
      chk("setup_penable", {31'd0, dut.penable_s}, 32'd0);
      if (k < n - 1) begin
        set_in(sq_rd[k+1], sq_a[k+1], sq_d[k+1]);
      end else begin
        transfer = 1'b0;
        scramble();
      end
      @(posedge pclk); #1;
      chk("access_state", 32'(dut.state_r), 32'(ACCESS));
      chk("access_penable", {31'd0, dut.penable_s}, 32'd1);
      chk("access_psel1", {31'd0, dut.psel1_s}, {31'd0, ~sq_a[k][8]});
      chk("access_rdo_hold", {24'd0, apb_read_data_out}, {24'd0, rdo_m});
      @(posedge pclk); #1;
      if (sq_rd[k]) rdo_m = mem_m[sq_a[k]];
      else mem_m[sq_a[k]] = sq_d[k];
      chk("done_rdo", {24'd0, apb_read_data_out}, {24'd0, rdo_m});
    end
    chk_idle("end");
  endtask

  task automatic one(input logic rd, input logic [8:0] a, input logic [7:0] d);
    sq_rd[0] = rd; sq_a[0] = a; sq_d[0] = d;
    run_seq(1);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    presetn  = 1'b1;
    transfer = 1'b0;
    scramble();
    model_reset();

    // Reset
    repeat (2) @(posedge pclk);
    #1;
    chk_idle("reset");
    presetn = 1'b0;

    // Unwritten location
    one(1'b1, 9'h1FF, 8'h00);
    chk("unwritten_1ff", {24'd0, apb_read_data_out}, 32'h00);

    // Write then read on slave 0
    one(1'b0, 9'h005, 8'hA5);
    chk("wr_no_rdo_change", {24'd0, apb_read_data_out}, 32'h00);
    one(1'b1, 9'h005, 8'h00);
    chk("rd_005", {24'd0, apb_read_data_out}, 32'hA5);

    // Slave 1 isolation
    one(1'b0, 9'h105, 8'h3C);
    one(1'b1, 9'h005, 8'h00);
    chk("iso_005", {24'd0, apb_read_data_out}, 32'hA5);
    one(1'b1, 9'h105, 8'h00);
    chk("iso_105", {24'd0, apb_read_data_out}, 32'h3C);

    // Back-to-back: two writes then a read
    sq_rd[0] = 1'b0; sq_a[0] = 9'h0AA; sq_d[0] = 8'h11;
    sq_rd[1] = 1'b0; sq_a[1] = 9'h1AA; sq_d[1] = 8'h22;
    sq_rd[2] = 1'b1; sq_a[2] = 9'h0AA; sq_d[2] = 8'h00;
    run_seq(3);
    chk("b2b_rd_0aa", {24'd0, apb_read_data_out}, 32'h11);

    // Mid-transfer reset during ACCESS of a write
    set_in(1'b0, 9'h010, 8'h77);
    transfer = 1'b1;
    @(posedge pclk); #1;
    transfer = 1'b0;
    @(posedge pclk); #1;
    chk("mid_access", 32'(dut.state_r), 32'(ACCESS));
    presetn = 1'b1;
    #1;
    model_reset();
    chk_idle("mid_rst");
    @(posedge pclk);
    @(posedge pclk); #1;
    presetn = 1'b0;
    one(1'b1, 9'h010, 8'h00);
    chk("mid_rd_010", {24'd0, apb_read_data_out}, 32'h00);
    one(1'b1, 9'h105, 8'h00);
    chk("mid_rd_105", {24'd0, apb_read_data_out}, 32'h00);

    // Randomized sequences over a small address pool on both slaves
    for (int t = 0; t < 40; t++) begin
      int n;
      int gap;
      n = int'($urandom_range(1, 3));
      for (int k = 0; k < n; k++) begin
        sq_rd[k] = 1'($urandom);
        sq_a[k]  = {1'($urandom), 4'd0, 4'($urandom_range(0, 15))};
        sq_d[k]  = 8'($urandom);
      end
      run_seq(n);
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        scramble();
        @(posedge pclk); #1;
        chk_idle("gap");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_modport.md
APB_MODPORT -- requirements
Module: apb_modport

Interface
REQ-001 Parameters SHALL be: AW, default 9, address width (bit AW-1 selects the slave); DW, default 8, data width.
REQ-002 pclk  input  1  single clock; all state updates on rising edge.
REQ-003 presetn  input  1  asynchronous, active-high reset; 1 = reset; the port keeps the codebase name despite the "n" suffix.
REQ-004 transfer  input  1  request a transfer; level-sensitive.
REQ-005 READ_WRITE  input  1  1 = read, 0 = write; sampled with transfer.
REQ-006 apb_write_paddr  input  AW  write address.
REQ-007 apb_read_paddr  input  AW  read address.
REQ-008 apb_write_data  input  DW  write data.
REQ-009 apb_read_data_out  output  DW  data returned by the last completed read.

Function
REQ-010 An internal APB master SHALL use the states IDLE, SETUP and ACCESS.
REQ-011 IDLE: psel=0 and penable=0; if transfer=1 at a rising edge, the master SHALL go to SETUP and capture READ_WRITE, the selected address (apb_read_paddr if read, apb_write_paddr if write) and apb_write_data.
REQ-012 SETUP: the master SHALL drive the captured paddr/pwrite/pwdata, assert psel of the addressed slave, hold penable=0, and always go to ACCESS on the next edge.
REQ-013 ACCESS: penable=1; on the edge where pready=1 the transfer SHALL complete; if transfer=1 the master goes to SETUP and recaptures the inputs, else it goes to IDLE.
REQ-014 Slave select SHALL be: paddr[AW-1]=0 -> slave 0 (psel1); paddr[AW-1]=1 -> slave 1 (psel2); exactly one psel is high in SETUP/ACCESS, both low in IDLE.
REQ-015 Each slave SHALL hold 2^(AW-1) words of DW bits, indexed by paddr[AW-2:0].
REQ-016 Each slave SHALL drive pready=1 whenever its psel and penable are both high (zero wait states).
REQ-017 On a write completion, the selected slave SHALL store pwdata at the indexed word; the other slave SHALL be unchanged.
REQ-018 On a read completion, the slave SHALL return prdata, and apb_read_data_out SHALL register it at the same edge.
REQ-019 apb_read_data_out SHALL hold its value until the next read completes; writes do not change it.
REQ-020 Latency: transfer sampled at edge N -> SETUP during N..N+1 -> ACCESS during N+1..N+2 -> completion at edge N+2; read data is visible after edge N+2; back-to-back transfers complete every 2 cycles.
REQ-021 Input changes during SETUP/ACCESS SHALL NOT affect the transfer in flight, since the captured values are used.
REQ-022 Reading an unwritten location SHALL return 0.
REQ-023 A write followed by a read of the same address SHALL return the written data.

Reset
REQ-024 While presetn=1, asynchronously: state=IDLE, psel1/psel2/penable=0, captured registers=0, apb_read_data_out=0, and all slave memory words=0.
REQ-025 Reset asserted mid-transfer SHALL abort it with no memory update; after release the master SHALL start in IDLE.

Structure
REQ-026 A shared package SHALL hold AW/DW defaults and the state enum (IDLE, SETUP, ACCESS).
REQ-027 Sub-module apb_slave (memory plus pready/prdata logic) SHALL be instantiated twice; the master FSM and data-out register live in apb_modport.

Verification
REQ-028 Reset: assert presetn=1 for 2 cycles -> apb_read_data_out=0 and the state is IDLE.
REQ-029 Write then read on slave 0: write 0x05 <- 0xA5, then read 0x05 -> apb_read_data_out=0xA5 after 2 cycles.
REQ-030 Slave 1 isolation: write 0x105 <- 0x3C, then read 0x005 -> 0xA5 and read 0x105 -> 0x3C.
REQ-031 Unwritten location: read 0x1FF after reset -> 0x00.
REQ-032 Back-to-back: hold transfer=1 across two writes and one read -> each completes at 2-cycle spacing; psel and penable toggle correctly.
REQ-033 Mid-transfer reset: assert presetn during ACCESS of a write of 0x77 to 0x010 -> a later read of 0x010 returns 0x00.
